// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n: N-way round-robin arbiter with grant hold, done/drop release
// and an optional hold quantum that pre-empts a long-running holder.
module rr_arbiter_n #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 8,
  localparam int unsigned IDW     = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           done,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           grant_valid,
  output logic           timeout
);

  localparam int unsigned    HCW      = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HCW-1:0] HOLD_MAX = HCW'(MAX_HOLD);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(N - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state, state_n;
  logic [IDW-1:0] ptr, ptr_n;
  logic [HCW-1:0] hold_cnt, hold_n;
  logic [N-1:0]   grant_n;
  logic [IDW-1:0] grant_id_n;
  logic           grant_valid_n;
  logic           timeout_n;

  logic           hit_quantum;
  logic           holder_req;
  logic           release_now;
  logic [IDW-1:0] ptr_after;
  logic [IDW-1:0] arb_ptr;
  logic           found;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] cand;
  logic [N-1:0]   winner_onehot;

  // Release detection and rotating-priority pick (uses the post-release pointer
  // so handover happens at the same edge as the release)
  always_comb begin : pick_logic
    int unsigned s;
    s           = 0;
    cand        = '0;
    found       = 1'b0;
    winner      = '0;
    hit_quantum = (MAX_HOLD != 0) && (hold_cnt == HOLD_MAX);
    holder_req  = req[grant_id];
    release_now = (state == BUSY) && (done || !holder_req || hit_quantum);
    ptr_after   = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
    arb_ptr     = release_now ? ptr_after : ptr;
    for (int unsigned i = 0; i < N; i++) begin
      s = 32'(arb_ptr) + i;
      if (s >= N) s = s - N;
      cand = IDW'(s);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
    winner_onehot = '0;
    if (found) winner_onehot[winner] = 1'b1;
  end

  // Next-state and registered-output computation for the IDLE/BUSY machine
  always_comb begin
    state_n       = state;
    ptr_n         = ptr;
    hold_n        = hold_cnt;
    grant_n       = grant;
    grant_id_n    = grant_id;
    grant_valid_n = grant_valid;
    timeout_n     = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_n       = BUSY;
          grant_n       = winner_onehot;
          grant_id_n    = winner;
          grant_valid_n = 1'b1;
          hold_n        = HCW'(1);
        end
      end
      BUSY: begin
        if (release_now) begin
          ptr_n     = ptr_after;
          // Quantum pulse only when neither done nor a request drop caused it
          timeout_n = hit_quantum && !done && holder_req;
          if (found) begin
            grant_n       = winner_onehot;
            grant_id_n    = winner;
            grant_valid_n = 1'b1;
            hold_n        = HCW'(1);
          end else begin
            state_n       = IDLE;
            grant_n       = '0;
            grant_id_n    = '0;
            grant_valid_n = 1'b0;
            hold_n        = '0;
          end
        end else if ((MAX_HOLD != 0) && (hold_cnt != HOLD_MAX)) begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers, asynchronously cleared by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      grant       <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      hold_cnt    <= hold_n;
      grant       <= grant_n;
      grant_id    <= grant_id_n;
      grant_valid <= grant_valid_n;
      timeout     <= timeout_n;
    end
  end

endmodule
